// File: rtl/rst_sequencer.sv
// Reset sequencer: merges board reset, debounced pushbutton, clock lock and an
// optional watchdog, then releases bus/interconnect, peripheral and CPU resets
// in order, STAGE_DELAY cycles apart. Records the cause of the last reset.
// Optional watchdog: define RST_SEQ_WDT_EN to enable it.
module rst_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STAGE_DELAY     = 8,
    parameter int unsigned WDT_TIMEOUT     = 1000
) (
    input  logic       clk_100MHz,
    input  logic       sysreset_n,
    input  logic       ext_reset_in,
    input  logic       dcm_locked,
    input  logic       wdt_kick,
    output logic       bus_struct_reset,
    output logic       interconnect_aresetn,
    output logic       peripheral_aresetn,
    output logic       mb_reset,
    output logic       seq_done,
    output logic [1:0] rst_cause
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ST_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STAGE_DELAY - 1);

    localparam logic [2:0] S_HOLD = 3'd0;
    localparam logic [2:0] S_BUS  = 3'd1;
    localparam logic [2:0] S_PERI = 3'd2;
    localparam logic [2:0] S_CPU  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;

    logic [1:0]      rst_sync;
    logic [1:0]      ext_sync;
    logic [1:0]      lock_sync;
    logic            rst_ok;
    logic            ext_synced;
    logic            locked_sync;
    logic            ext_req_q;
    logic            ext_req_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic [2:0]      state_q;
    logic [2:0]      state_d;
    logic [ST_W-1:0] cnt_q;
    logic [ST_W-1:0] cnt_d;
    logic [1:0]      cause_d;
    logic            wdt_expire;
    logic            req;

    assign rst_ok      = rst_sync[1];
    assign ext_synced  = ext_sync[1];
    assign locked_sync = lock_sync[1];
    assign req         = ext_req_q | ~locked_sync | wdt_expire;

    // Two-flop synchronizers for reset release, pushbutton and lock status
    always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
        if (!sysreset_n) begin
            rst_sync  <= 2'b00;
            ext_sync  <= 2'b00;
            lock_sync <= 2'b00;
        end else begin
            rst_sync  <= {rst_sync[0], 1'b1};
            ext_sync  <= {ext_sync[0], ext_reset_in};
            lock_sync <= {lock_sync[0], dcm_locked};
        end
    end

    // Debounce: toggle ext_req after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        ext_req_d = ext_req_q;
        db_cnt_d  = '0;
        if (ext_synced != ext_req_q) begin
            if (db_cnt_q == DB_LAST) begin
                ext_req_d = ~ext_req_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Debounce state
    always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
        if (!sysreset_n) begin
            ext_req_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            ext_req_q <= ext_req_d;
            db_cnt_q  <= db_cnt_d;
        end
    end

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WDT_W = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

    logic [WDT_W-1:0] wdt_cnt_q;

    // A kick on the terminal cycle suppresses the expiry
    assign wdt_expire = (state_q == S_RUN) && (wdt_cnt_q == WDT_LAST) && !wdt_kick;

    // Watchdog counts only while staying in S_RUN without a kick
    always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
        if (!sysreset_n) begin
            wdt_cnt_q <= '0;
        end else if ((state_q == S_RUN) && (state_d == S_RUN) && !wdt_kick) begin
            wdt_cnt_q <= wdt_cnt_q + 1'b1;
        end else begin
            wdt_cnt_q <= '0;
        end
    end
`else
    logic wdt_unused;

    assign wdt_expire = 1'b0;
    assign wdt_unused = wdt_kick | (WDT_TIMEOUT == 0);
`endif

    // Next-state, stage counter and reset-cause capture
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cause_d = rst_cause;
        if (req) begin
            state_d = S_HOLD;
            if (state_q != S_HOLD) begin
                if (!locked_sync) begin
                    cause_d = 2'b10;
                end else if (ext_req_q) begin
                    cause_d = 2'b01;
                end else begin
                    cause_d = 2'b11;
                end
            end
        end else begin
            case (state_q)
                S_HOLD: if (rst_ok) state_d = S_BUS;
                S_BUS: begin
                    if (cnt_q == ST_LAST) state_d = S_PERI;
                    else cnt_d = cnt_q + 1'b1;
                end
                S_PERI: begin
                    if (cnt_q == ST_LAST) state_d = S_CPU;
                    else cnt_d = cnt_q + 1'b1;
                end
                S_CPU: begin
                    if (cnt_q == ST_LAST) state_d = S_RUN;
                    else cnt_d = cnt_q + 1'b1;
                end
                S_RUN:   state_d = S_RUN;
                default: state_d = S_HOLD;
            endcase
        end
    end

    // State, counter and registered outputs decoded from the state being entered
    always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q              <= S_HOLD;
            cnt_q                <= '0;
            rst_cause            <= 2'b00;
            bus_struct_reset     <= 1'b1;
            interconnect_aresetn <= 1'b0;
            peripheral_aresetn   <= 1'b0;
            mb_reset             <= 1'b1;
            seq_done             <= 1'b0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            rst_cause            <= cause_d;
            bus_struct_reset     <= (state_d == S_HOLD) || (state_d == S_BUS);
            interconnect_aresetn <= (state_d != S_HOLD) && (state_d != S_BUS);
            peripheral_aresetn   <= (state_d == S_CPU) || (state_d == S_RUN);
            mb_reset             <= (state_d != S_RUN);
            seq_done             <= (state_d == S_RUN);
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios followed by random stimulus.
// A timeline model predicts every change of the output vector; a monitor
// compares each observed change against the predicted one.
module tb_rst_sequencer;

    localparam int S = 8;
    localparam int D = 4;
    localparam int T = 20;
`ifdef RST_SEQ_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sysreset_n = 1'b0;
    logic       ext_reset_in = 1'b0;
    logic       dcm_locked = 1'b1;
    logic       wdt_kick = 1'b0;
    logic       bus_struct_reset;
    logic       interconnect_aresetn;
    logic       peripheral_aresetn;
    logic       mb_reset;
    logic       seq_done;
    logic [1:0] rst_cause;

    rst_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .STAGE_DELAY    (S),
        .WDT_TIMEOUT    (T)
    ) dut (
        .clk_100MHz          (clk),
        .sysreset_n          (sysreset_n),
        .ext_reset_in        (ext_reset_in),
        .dcm_locked          (dcm_locked),
        .wdt_kick            (wdt_kick),
        .bus_struct_reset    (bus_struct_reset),
        .interconnect_aresetn(interconnect_aresetn),
        .peripheral_aresetn  (peripheral_aresetn),
        .mb_reset            (mb_reset),
        .seq_done            (seq_done),
        .rst_cause           (rst_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  kick_mode = 0;

    // Model state: timeline since sequencing began, not an FSM
    int  m_t = -1;          // edges since entering bus stage, -1 while held
    int  m_rel = 0;         // edges since sysreset_n release (saturates at 2)
    bit  m_e1, m_e2, m_l1, m_l2;
    bit  m_ext_req;
    int  m_run_len;
    int  m_run_at, m_kick_at;
    logic [1:0] m_cause;

    function automatic logic [6:0] model_vec();
        if (m_t < 0) return {5'b10010, m_cause};
        return {m_t < S, m_t >= S, m_t >= 2 * S, m_t < 3 * S, m_t >= 3 * S, m_cause};
    endfunction

    // Reference model: advance on every clock edge from the inputs seen at that edge
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!sysreset_n) begin
            m_t = -1; m_rel = 0; m_e1 = 0; m_e2 = 0; m_l1 = 0; m_l2 = 0;
            m_ext_req = 0; m_run_len = 0; m_cause = 2'b00; m_run_at = 0; m_kick_at = 0;
        end else begin
            bit ext_s, lock_s, running, wexp, req;
            int base;
            ext_s   = m_e2;
            lock_s  = m_l2;
            running = (m_t == 3 * S);
            base    = (m_run_at > m_kick_at) ? m_run_at : m_kick_at;
            wexp    = WDT_ON && running && (cyc - base == T) && !wdt_kick;
            req     = m_ext_req || !lock_s || wexp;
            if (req) begin
                if (m_t >= 0) m_cause = !lock_s ? 2'b10 : (m_ext_req ? 2'b01 : 2'b11);
                m_t = -1;
            end else if (m_t < 0) begin
                if (m_rel >= 2) m_t = 0;
            end else if (m_t < 3 * S) begin
                m_t++;
                if (m_t == 3 * S) m_run_at = cyc;
            end
            if (wdt_kick) m_kick_at = cyc;
            if (ext_s != m_ext_req) begin
                m_run_len++;
                if (m_run_len == D) begin
                    m_ext_req = !m_ext_req;
                    m_run_len = 0;
                end
            end else begin
                m_run_len = 0;
            end
            m_e2 = m_e1; m_e1 = ext_reset_in;
            m_l2 = m_l1; m_l1 = dcm_locked;
            if (m_rel < 2) m_rel++;
        end
    end

    // Predictor: push every change of the expected output vector
    initial begin
        logic [6:0] last_exp, v;
        bit first;
        first = 1;
        last_exp = '0;
        forever begin
            @(negedge clk);
            v = sysreset_n ? model_vec() : 7'b1001000;
            if (first || v != last_exp) begin
                exp_q.push_back('{cyc: cyc, vec: v});
                last_exp = v;
                first = 0;
            end
        end
    end

    // Monitor: compare every observed output change with the next prediction
    initial begin
        logic [6:0] last_seen, cur;
        bit first;
        ev_t e;
        first = 1;
        last_seen = '0;
        forever begin
            @(negedge clk);
            #1;
            cur = {bus_struct_reset, interconnect_aresetn, peripheral_aresetn,
                   mb_reset, seq_done, rst_cause};
            if (first || cur !== last_seen) begin
                first = 0;
                last_seen = cur;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cycle %0d outputs %b, none predicted",
                             cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== cur) begin
                        errors++;
                        $display("FAIL output_event: got cycle %0d outputs %b, expected cycle %0d outputs %b",
                                 cyc, cur, e.cyc, e.vec);
                    end
                end
            end
        end
    end

    // Watchdog kicker: 0 off, 1 every 15 cycles, 2 random
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            case (kick_mode)
                1: begin
                    div++;
                    wdt_kick = (div % 15 == 0);
                end
                2:       wdt_kick = ($urandom_range(0, 11) == 0);
                default: wdt_kick = 1'b0;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int rst_left, lock_left, bounce;
        bit ext_tgt;
        kick_mode = 1;
        // Power-on: board reset held 10 cycles, then staged release
        tick(10);
        sysreset_n = 1;
        tick(40);
        // Bouncy pushbutton that never settles long enough
        ext_reset_in = 1; tick(1);
        ext_reset_in = 0; tick(1);
        ext_reset_in = 1; tick(1);
        ext_reset_in = 0; tick(10);
        // Steady press then release
        ext_reset_in = 1; tick(6);
        ext_reset_in = 0; tick(45);
        // Lock loss for one cycle during the peripheral stage
        sysreset_n = 0; tick(2);
        sysreset_n = 1; tick(14);
        dcm_locked = 0; tick(1);
        dcm_locked = 1; tick(45);
        // Pushbutton and lock loss reaching the request on the same edge
        ext_reset_in = 1; tick(4);
        dcm_locked = 0; tick(10);
        dcm_locked = 1; ext_reset_in = 0; tick(45);
        // Board reset pulsed mid CPU stage
        sysreset_n = 0; tick(2);
        sysreset_n = 1; tick(22);
        sysreset_n = 0; tick(2);
        sysreset_n = 1; tick(40);
        // Watchdog: regular kicks, then none
        kick_mode = 1; tick(100);
        kick_mode = 0; tick(60);
        // Random stimulus
        kick_mode = 2;
        rst_left = 0; lock_left = 0; bounce = 0; ext_tgt = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 3);
            sysreset_n = (rst_left == 0);
            if (lock_left > 0) lock_left--;
            else if ($urandom_range(0, 249) == 0) lock_left = $urandom_range(1, 5);
            dcm_locked = (lock_left == 0);
            if (bounce > 0) begin
                bounce--;
                ext_reset_in = 1'($urandom_range(0, 1));
            end else begin
                if ($urandom_range(0, 79) == 0) begin
                    ext_tgt = !ext_tgt;
                    bounce = $urandom_range(0, 4);
                end
                ext_reset_in = ext_tgt;
            end
            tick(1);
        end
        kick_mode = 0;
        sysreset_n = 1; dcm_locked = 1; ext_reset_in = 0;
        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d predicted changes not observed, first at cycle %0d",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
